sample_spi_receiver: RTL and testbench

- SPI slave that receives the 24-bit frames produced by the DAC output path: 8-bit channel command followed by 16-bit offset-binary data.
- Recovers signed 32-bit samples in the i_Clock domain and pairs L (channel A) with R (channel B).
- Presents each completed pair with a one-cycle valid strobe.
- Used for board-to-board sample links and for loopback verification of the output path.

---
 rtl/sample_spi_receiver.sv | 117 +++++++++++
 tb/tb_sample_spi_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sample_spi_receiver.sv
// sample_spi_receiver: SPI slave decoding 24-bit L/R DAC frames into signed 32-bit sample pairs.
// Optional error counter output o_Error_Count is enabled by SAMPLE_SPI_RECEIVER_STATS_EN.
module sample_spi_receiver #(
  parameter logic [31:0] SAMPLE_OFFSET  = 32'h1FFFF,
  parameter logic [7:0]  RECV_CHANNEL_A = 8'b00110001,
  parameter logic [7:0]  RECV_CHANNEL_B = 8'b00110010
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_SPI_CS,
  input  logic               i_SPI_Clock,
  input  logic               i_SPI_Data,
  output logic signed [31:0] o_Sample_L,
  output logic signed [31:0] o_Sample_R,
  output logic               o_Valid,
  output logic               o_Error,
  output logic               o_Busy
`ifdef SAMPLE_SPI_RECEIVER_STATS_EN
  ,
  output logic [7:0]         o_Error_Count
`endif
);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, SHIFT, CHECK, CONVERT, PUBLISH} state_t;
  state_t state_q, state_d;
  logic [2:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic [31:0] left_q, left_d, sample_l_q, sample_l_d, sample_r_q, sample_r_d, word;
  logic cs_rise, cs_fall, sclk_rise, err;
  always_comb begin
    cs_sync_d = {cs_sync_q[1:0], i_SPI_CS};
    sclk_sync_d = {sclk_sync_q[1:0], i_SPI_Clock};
    data_sync_d = {data_sync_q[0], i_SPI_Data};
    cs_rise = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall = ~cs_sync_q[1] & cs_sync_q[2];
    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    word = {14'b0, shift_q[15:0], 2'b00} - SAMPLE_OFFSET;
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    left_d = left_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    err = 1'b0;
    case (state_q)
      WAIT_IDLE: state_d = cs_sync_q[1] ? IDLE : WAIT_IDLE;
      IDLE: begin
        if (cs_fall) begin
          cnt_d = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[22:0], data_sync_q[1]};
          cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end
        if (cs_rise) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (cnt_q == 5'd24 && shift_q[23:16] == RECV_CHANNEL_A) begin
          left_d = word;
          pend_d = 1'b1;
        end else if (cnt_q == 5'd24 && shift_q[23:16] == RECV_CHANNEL_B && pend_q) state_d = CONVERT;
        else err = 1'b1;
      end
      CONVERT: begin
        sample_r_d = word;
        sample_l_d = left_q;
        pend_d = 1'b0;
        state_d = PUBLISH;
      end
      PUBLISH: state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= WAIT_IDLE;
      cs_sync_q <= '0;
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      shift_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      left_q <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
    end else begin
      state_q <= state_d;
      cs_sync_q <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      data_sync_q <= data_sync_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      left_q <= left_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
    end
  end
  assign o_Sample_L = sample_l_q;
  assign o_Sample_R = sample_r_q;
  assign o_Valid = state_q == PUBLISH;
  assign o_Busy = state_q == SHIFT;
  assign o_Error = err;
`ifdef SAMPLE_SPI_RECEIVER_STATS_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge i_Clock) err_cnt_q <= i_Reset ? 8'd0 : err_cnt_d;
  assign o_Error_Count = err_cnt_q;
`endif
endmodule

// File: tb/tb_sample_spi_receiver.sv
// tb_sample_spi_receiver: directed SPI frames checked against a frame-level model of the receiver.
module tb_sample_spi_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1, sclk = 1'b0, sdata = 1'b0;
  logic signed [31:0] sample_l, sample_r;
  logic valid, error, busy;
`ifdef SAMPLE_SPI_RECEIVER_STATS_EN
  logic [7:0] err_count;
`endif
  int checks = 0, failures = 0;
  int valid_seen = 0, err_seen = 0, exp_valid = 0, exp_err = 0;
  int cur_l = 0, cur_r = 0, m_hold = 0, lat = 0;
  bit m_pend = 0, prev_v = 0, prev_e = 0;
  int ql[$], qr[$];

  always #5 clk = ~clk;

  sample_spi_receiver dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_SPI_CS(cs),
    .i_SPI_Clock(sclk),
    .i_SPI_Data(sdata),
    .o_Sample_L(sample_l),
    .o_Sample_R(sample_r),
    .o_Valid(valid),
    .o_Error(error),
    .o_Busy(busy)
`ifdef SAMPLE_SPI_RECEIVER_STATS_EN
    ,
    .o_Error_Count(err_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic int conv(input logic [15:0] d);
    return 4 * int'(d) - 131071;
  endfunction

  // Frame-level model: what a completed frame of n bits means for pairing and errors.
  task automatic model(input logic [31:0] v, input int n);
    if (n != 24) exp_err++;
    else if (v[23:16] == 8'h31) begin
      m_hold = conv(v[15:0]);
      m_pend = 1;
    end else if (v[23:16] == 8'h32 && m_pend) begin
      ql.push_back(m_hold);
      qr.push_back(conv(v[15:0]));
      m_pend = 0;
      exp_valid++;
    end else exp_err++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cur_l = 0;
      cur_r = 0;
      prev_v = 0;
      prev_e = 0;
    end else begin
      if (valid) begin
        valid_seen++;
        chk("valid_expected", 32'(ql.size() != 0), 32'd1);
        if (ql.size() != 0) begin
          cur_l = ql.pop_front();
          cur_r = qr.pop_front();
        end
      end
      if (error) err_seen++;
      chk("valid_one_cycle", 32'(valid & prev_v), 32'd0);
      chk("error_one_cycle", 32'(error & prev_e), 32'd0);
      chk("sample_l", sample_l, cur_l);
      chk("sample_r", sample_r, cur_r);
      prev_v = valid;
      prev_e = error;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    sdata = b;
    tick(4);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic check_counts();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("valid_count", valid_seen, exp_valid);
    chk("error_count", err_seen, exp_err);
`ifdef SAMPLE_SPI_RECEIVER_STATS_EN
    chk("stats_count", 32'(err_count), (exp_err > 255) ? 255 : exp_err);
`endif
  endtask

  task automatic send(input logic [31:0] v, input int n);
    cs = 1'b0;
    tick(4);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    tick(4);
    cs = 1'b1;
    model(v, n);
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (valid && lat == 0) lat = k;
    end
    check_counts();
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(6);
    chk("reset_l", sample_l, 0);
    chk("reset_r", sample_r, 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_error", 32'(error), 0);
    chk("reset_busy", 32'(busy), 0);
    send(32'h318000, 24);
    send(32'h32FFFF, 24);
    chk("t1_l", sample_l, 1);
    chk("t1_r", sample_r, 131069);
    chk("t1_err", err_seen, 0);
    send(32'h310000, 24);
    send(32'h327FFF, 24);
    chk("t2_latency", lat, 5);
    chk("t2_l", sample_l, -131071);
    chk("t2_r", sample_r, -3);
    send(32'h188000, 23);
    send(32'h318000, 24);
    send(32'h328000, 24);
    chk("t3_l", sample_l, 1);
    chk("t3_r", sample_r, 1);
    send(32'h310004, 24);
    send(32'hC60000, 26);
    send(32'h320000, 24);
    chk("t3b_l", sample_l, -131055);
    chk("t3b_r", sample_r, -131071);
    chk("t3b_err", err_seen, 2);
    send(32'h328000, 24);
    send(32'h338000, 24);
    chk("t4_err", err_seen, 4);
    send(32'h318000, 24);
    cs = 1'b0;
    tick(4);
    for (int i = 23; i >= 12; i--) shift_bit(1'(32'h32FFFF >> i));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_pend = 0;
    for (int i = 11; i >= 0; i--) shift_bit(1'(32'h32FFFF >> i));
    tick(4);
    cs = 1'b1;
    tick(16);
    check_counts();
    chk("t5_reset_l", sample_l, 0);
    send(32'h32FFFF, 24);
    send(32'h310000, 24);
    send(32'h32FFFF, 24);
    chk("t5_l", sample_l, -131071);
    chk("t5_r", sample_r, 131069);
    send(32'h310004, 24);
    send(32'h318000, 24);
    send(32'h320000, 24);
    chk("t6_l", sample_l, 1);
    chk("t6_r", sample_r, -131071);
    repeat (5) begin
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    check_counts();
    send(32'h31FFFF, 24);
    send(32'h310000, 24);
    send(32'h328000, 24);
    chk("t7_l", sample_l, -131071);
    chk("t7_r", sample_r, 1);
    chk("final_valid", valid_seen, 7);
    chk("final_err", err_seen, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
